// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Memory-stage producer wins over writeback; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use/redirect/memory-wait
// stall and flush generation, memory timeout FSM and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       ResultSrc_e,
  input  logic             PCSrc_e,
  input  logic [4:0]       rd_m,
  input  logic             RegWrite_m,
  input  logic [4:0]       rd_w,
  input  logic             RegWrite_w,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       ForwardA_e,
  output logic [1:0]       ForwardB_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  hz_state_t  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic lw_stall;
  logic mem_stall;

  assign lw_stall = (ResultSrc_e == RESULT_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  assign mem_stall = (((state_q == RUN) || (state_q == MEM_WAIT)) && mem_req_m && !mem_ready) ||
                     (state_q == ERROR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_m && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR: begin
        // Terminal until reset; mem_ready is deliberately ignored here.
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    ForwardA_e = FWD_RF;
    ForwardB_e = FWD_RF;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      ForwardA_e = fwd_select(rs1_e, rd_m, RegWrite_m, rd_w, RegWrite_w);
      ForwardB_e = fwd_select(rs2_e, rd_m, RegWrite_m, rd_w, RegWrite_w);
      if (mem_stall) begin
        // Redirect is held off until E unfreezes.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (PCSrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .count (stall_cycles)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_d),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_WAIT=4, 4-bit counters).
module tb_hazard_ctrl;
  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]      ResultSrc_e;
  logic            PCSrc_e, RegWrite_m, RegWrite_w, mem_req_m, mem_ready;
  logic [1:0]      ForwardA_e, ForwardB_e;
  logic            stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
  logic [CntW-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .ResultSrc_e  (ResultSrc_e),
    .PCSrc_e      (PCSrc_e),
    .rd_m         (rd_m),
    .RegWrite_m   (RegWrite_m),
    .rd_w         (rd_w),
    .RegWrite_w   (RegWrite_w),
    .mem_req_m    (mem_req_m),
    .mem_ready    (mem_ready),
    .ForwardA_e   (ForwardA_e),
    .ForwardB_e   (ForwardB_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e}.
  function automatic logic [5:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd5; rs2_e = 5'd0; rd_e = 5'd0;
    rd_m = 5'd5; rd_w = 5'd5; RegWrite_m = 1'b1; RegWrite_w = 1'b1;
    ResultSrc_e = 2'b00; PCSrc_e = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0;
    tick();
    #1;
    chk("rst_ctl", 32'(ctl()), 32'b000011);
    chk("rst_fwd_a", 32'(ForwardA_e), 32'd0);
    chk("rst_cnt_stall", 32'(stall_cycles), 32'd0);
    chk("rst_cnt_flush", 32'(flush_events), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);

    rst = 1'b0;
    #1;
    chk("fwd_a_mem", 32'(ForwardA_e), 32'b10);
    rd_m = 5'd0; rs2_e = 5'd5;
    #1;
    chk("fwd_a_wb", 32'(ForwardA_e), 32'b01);
    chk("fwd_b_wb", 32'(ForwardB_e), 32'b01);
    RegWrite_w = 1'b0;
    #1;
    chk("fwd_a_rf", 32'(ForwardA_e), 32'b00);
    chk("idle_ctl", 32'(ctl()), 32'b000000);

    // Load with rd=x0 must not stall.
    ResultSrc_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    chk("lw_x0", 32'(ctl()), 32'b000000);
    rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    chk("lw_stall", 32'(ctl()), 32'b110001);
    tick();
    ResultSrc_e = 2'b00;
    #1;
    chk("lw_cnt_stall", 32'(stall_cycles), 32'd1);
    chk("lw_cnt_flush", 32'(flush_events), 32'd0);

    ResultSrc_e = 2'b01; PCSrc_e = 1'b1;
    #1;
    chk("redir_lw", 32'(ctl()), 32'b000011);
    tick();
    ResultSrc_e = 2'b00; PCSrc_e = 1'b0;
    #1;
    chk("redir_cnt_flush", 32'(flush_events), 32'd1);
    chk("redir_cnt_stall", 32'(stall_cycles), 32'd1);

    mem_req_m = 1'b1; mem_ready = 1'b0; PCSrc_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("memwait_%0d", i), 32'(ctl()), 32'b111100);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("memwait_release", 32'(ctl()), 32'b000011);
    tick();
    mem_req_m = 1'b0; mem_ready = 1'b0; PCSrc_e = 1'b0;
    #1;
    chk("memwait_cnt_stall", 32'(stall_cycles), 32'd4);
    chk("memwait_cnt_flush", 32'(flush_events), 32'd2);
    chk("memwait_idle", 32'(ctl()), 32'b000000);

    mem_req_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_wait_%0d", i), 32'(ctl()), 32'b111100);
      chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), 32'd0);
      tick();
    end
    #1;
    chk("to_set", 32'(mem_timeout), 32'd1);
    mem_ready = 1'b1; mem_req_m = 1'b0;
    tick();
    #1;
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_hold", 32'(ctl()), 32'b111100);
    for (int i = 0; i < 12; i++) tick();
    chk("cnt_saturate", 32'(stall_cycles), 32'hF);
    chk("to_cnt_flush", 32'(flush_events), 32'd2);

    rst = 1'b1;
    #1;
    chk("rst2_ctl", 32'(ctl()), 32'b000011);
    tick();
    rst = 1'b0; mem_req_m = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst2_timeout", 32'(mem_timeout), 32'd0);
    chk("rst2_cnt_stall", 32'(stall_cycles), 32'd0);
    chk("rst2_cnt_flush", 32'(flush_events), 32'd0);
    chk("rst2_run", 32'(ctl()), 32'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
